// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the memory port arbiter.
// The FSM states and owner ids also set the meaning of the registered owner field.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_STK = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input picker for the ifu/stk ports.
// It runs round-robin on last_owner, or lets stk win every tie when FIXED_PRIO is set.
module rr_arb2
  import mem_port_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ifu_req_i,
  input  logic stk_req_i,
  output logic ifu_gnt_o,
  output logic stk_gnt_o
);

  owner_e last_owner_q, last_owner_d;
  logic   stk_wins;

  always_comb begin
    stk_wins     = (FIXED_PRIO != 0) || (last_owner_q == OWN_IFU);
    stk_gnt_o    = en_i && stk_req_i && (!ifu_req_i || stk_wins);
    ifu_gnt_o    = en_i && ifu_req_i && (!stk_req_i || !stk_wins);
    last_owner_d = last_owner_q;
    if (stk_gnt_o)      last_owner_d = OWN_STK;
    else if (ifu_gnt_o) last_owner_d = OWN_IFU;
  end

  always_ff @(posedge clk) begin
    if (!rst) last_owner_q <= OWN_IFU;
    else      last_owner_q <= last_owner_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port registered-read memory between the instruction-fetch and stack ports.
// Each grant becomes one ACCESS strobe, followed by a RESP cycle that pulses the owner's done.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_done,
  input  logic              stk_req,
  input  logic              stk_we,
  input  logic [ADDR_W-1:0] stk_addr,
  input  logic [DATA_W-1:0] stk_wdata,
  output logic              stk_gnt,
  output logic              stk_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e            state_q, state_d;
  owner_e            own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              win_open;

  // Grants open in IDLE and RESP only, so RESP can overlap the next request.
  assign win_open = rst && ((state_q == IDLE) || (state_q == RESP));

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (win_open),
    .ifu_req_i (ifu_req),
    .stk_req_i (stk_req),
    .ifu_gnt_o (ifu_gnt),
    .stk_gnt_o (stk_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, RESP: state_d = (ifu_gnt || stk_gnt) ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we   = rst && (state_q == ACCESS) && we_q;
    mem_re   = rst && (state_q == ACCESS) && !we_q;
    ifu_done = rst && (state_q == RESP) && (own_q == OWN_IFU);
    stk_done = rst && (state_q == RESP) && (own_q == OWN_STK);
    rdata    = (state_q == RESP) ? mem_rd : '0;
    mem_addr = addr_q;
    mem_wd   = wd_q;
  end

  // The captured request stays on the memory bus until the next grant replaces it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q  <= OWN_IFU;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
    end else if (stk_gnt) begin
      own_q  <= OWN_STK;
      we_q   <= stk_we;
      addr_q <= stk_addr;
      wd_q   <= stk_wdata;
    end else if (ifu_gnt) begin
      own_q  <= OWN_IFU;
      we_q   <= 1'b0;
      addr_q <= ifu_addr;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus, and each drives its own behavioural 32x8 memory.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ifu_req, stk_req, stk_we;
  logic [4:0] ifu_addr, stk_addr;
  logic [7:0] stk_wdata;

  logic       d0_ifu_gnt, d0_ifu_done, d0_stk_gnt, d0_stk_done, d0_we, d0_re;
  logic [7:0] d0_rdata, d0_wd, d0_rd;
  logic [4:0] d0_addr;
  logic       d1_ifu_gnt, d1_ifu_done, d1_stk_gnt, d1_stk_done, d1_we, d1_re;
  logic [7:0] d1_rdata, d1_wd, d1_rd;
  logic [4:0] d1_addr;

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(d0_ifu_gnt), .ifu_done(d0_ifu_done),
    .stk_req(stk_req), .stk_we(stk_we), .stk_addr(stk_addr), .stk_wdata(stk_wdata),
    .stk_gnt(d0_stk_gnt), .stk_done(d0_stk_done), .rdata(d0_rdata),
    .mem_we(d0_we), .mem_re(d0_re), .mem_addr(d0_addr), .mem_wd(d0_wd), .mem_rd(d0_rd)
  );

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(d1_ifu_gnt), .ifu_done(d1_ifu_done),
    .stk_req(stk_req), .stk_we(stk_we), .stk_addr(stk_addr), .stk_wdata(stk_wdata),
    .stk_gnt(d1_stk_gnt), .stk_done(d1_stk_done), .rdata(d1_rdata),
    .mem_we(d1_we), .mem_re(d1_re), .mem_addr(d1_addr), .mem_wd(d1_wd), .mem_rd(d1_rd)
  );

  always @(posedge clk) begin
    if (d0_we) mem0[d0_addr] <= d0_wd;
    if (d0_re) d0_rd <= mem0[d0_addr];
    if (d1_we) mem1[d1_addr] <= d1_wd;
    if (d1_re) d1_rd <= mem1[d1_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  logic [7:0] e0_sg, e0_ig, e0_sd, e0_id, e1_sg, e1_sd;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[3] = 8'hA5; mem1[3] = 8'hA5;
    mem0[7] = 8'h11; mem1[7] = 8'h11;
    rst = 1'b0; ifu_req = 1'b0; stk_req = 1'b0; stk_we = 1'b0;
    ifu_addr = '0; stk_addr = '0; stk_wdata = '0;

    // reset state
    nxt(); nxt(); settle();
    chk("rst_ifu_gnt", 8'(d0_ifu_gnt), 8'd0);
    chk("rst_stk_gnt", 8'(d0_stk_gnt), 8'd0);
    chk("rst_done", 8'({d0_ifu_done, d0_stk_done}), 8'd0);
    chk("rst_mem_strobe", 8'({d0_we, d0_re}), 8'd0);
    chk("rst_mem_addr", 8'(d0_addr), 8'd0);
    chk("rst_mem_wd", d0_wd, 8'd0);
    chk("rst_rdata", d0_rdata, 8'd0);

    // single fetch of word 3
    nxt(); rst = 1'b1; ifu_req = 1'b1; ifu_addr = 5'd3; settle();
    chk("f_ifu_gnt", 8'(d0_ifu_gnt), 8'd1);
    chk("f_stk_gnt", 8'(d0_stk_gnt), 8'd0);
    nxt(); ifu_req = 1'b0; settle();
    chk("f_mem_re", 8'(d0_re), 8'd1);
    chk("f_mem_we", 8'(d0_we), 8'd0);
    chk("f_mem_addr", 8'(d0_addr), 8'd3);
    chk("f_no_gnt_access", 8'(d0_ifu_gnt), 8'd0);
    nxt(); settle();
    chk("f_ifu_done", 8'(d0_ifu_done), 8'd1);
    chk("f_rdata", d0_rdata, 8'hA5);
    chk("f_stk_done", 8'(d0_stk_done), 8'd0);

    // stack write then read of address 10
    nxt(); stk_req = 1'b1; stk_we = 1'b1; stk_addr = 5'd10; stk_wdata = 8'h3C; settle();
    chk("w_stk_gnt", 8'(d0_stk_gnt), 8'd1);
    nxt(); stk_we = 1'b0; settle();
    chk("w_mem_we", 8'(d0_we), 8'd1);
    chk("w_mem_re", 8'(d0_re), 8'd0);
    chk("w_mem_addr", 8'(d0_addr), 8'd10);
    chk("w_mem_wd", d0_wd, 8'h3C);
    chk("w_no_gnt_access", 8'(d0_stk_gnt), 8'd0);
    nxt(); settle();
    chk("w_stk_done", 8'(d0_stk_done), 8'd1);
    chk("r_gnt_in_resp", 8'(d0_stk_gnt), 8'd1);
    nxt(); stk_req = 1'b0; settle();
    chk("r_mem_we", 8'(d0_we), 8'd0);
    chk("r_mem_re", 8'(d0_re), 8'd1);
    chk("r_mem_addr", 8'(d0_addr), 8'd10);
    nxt(); settle();
    chk("r_stk_done", 8'(d0_stk_done), 8'd1);
    chk("r_rdata", d0_rdata, 8'h3C);
    chk("r_ifu_done", 8'(d0_ifu_done), 8'd0);

    // simultaneous requests from reset
    nxt(); rst = 1'b0;
    e0_sg = 8'b0001_0001; e0_ig = 8'b0100_0100;
    e0_sd = 8'b0100_0100; e0_id = 8'b0001_0000;
    e1_sg = 8'b0101_0101; e1_sd = 8'b0101_0100;
    for (int c = 0; c < 8; c++) begin
      nxt();
      rst = 1'b1; ifu_req = 1'b1; ifu_addr = 5'd3;
      stk_req = 1'b1; stk_we = 1'b0; stk_addr = 5'd10;
      settle();
      chk($sformatf("rr_stk_gnt_c%0d", c), 8'(d0_stk_gnt), 8'(e0_sg[c]));
      chk($sformatf("rr_ifu_gnt_c%0d", c), 8'(d0_ifu_gnt), 8'(e0_ig[c]));
      chk($sformatf("rr_stk_done_c%0d", c), 8'(d0_stk_done), 8'(e0_sd[c]));
      chk($sformatf("rr_ifu_done_c%0d", c), 8'(d0_ifu_done), 8'(e0_id[c]));
      chk($sformatf("fp_stk_gnt_c%0d", c), 8'(d1_stk_gnt), 8'(e1_sg[c]));
      chk($sformatf("fp_ifu_gnt_c%0d", c), 8'(d1_ifu_gnt), 8'd0);
      chk($sformatf("fp_stk_done_c%0d", c), 8'(d1_stk_done), 8'(e1_sd[c]));
      chk($sformatf("fp_ifu_done_c%0d", c), 8'(d1_ifu_done), 8'd0);
      if (c == 2) chk("rr_rdata_stk", d0_rdata, 8'h3C);
      if (c == 4) chk("rr_rdata_ifu", d0_rdata, 8'hA5);
    end
    nxt(); ifu_req = 1'b0; stk_req = 1'b0;
    nxt(); nxt();

    // reset lands during the ACCESS cycle of a write to word 7
    nxt(); stk_req = 1'b1; stk_we = 1'b1; stk_addr = 5'd7; stk_wdata = 8'hFF; settle();
    chk("x_stk_gnt", 8'(d0_stk_gnt), 8'd1);
    nxt(); stk_req = 1'b0; stk_we = 1'b0; rst = 1'b0; settle();
    chk("x_mem_we_blocked", 8'(d0_we), 8'd0);
    nxt(); rst = 1'b1; settle();
    chk("x_stk_done", 8'(d0_stk_done), 8'd0);
    chk("x_strobes", 8'({d0_we, d0_re}), 8'd0);
    chk("x_mem_addr", 8'(d0_addr), 8'd0);
    chk("x_mem_wd", d0_wd, 8'd0);
    chk("x_rdata", d0_rdata, 8'd0);
    chk("x_mem7_untouched", mem0[7], 8'h11);
    chk("x_mem7_untouched_fp", mem1[7], 8'h11);

    // idle stretch: nothing moves
    for (int c = 0; c < 5; c++) begin
      nxt(); settle();
      chk($sformatf("idle_strobes_c%0d", c), 8'({d0_we, d0_re}), 8'd0);
      chk($sformatf("idle_gnt_c%0d", c), 8'({d0_ifu_gnt, d0_stk_gnt}), 8'd0);
      chk($sformatf("idle_done_c%0d", c), 8'({d0_ifu_done, d0_stk_done}), 8'd0);
    end

    // fetch word 7 back; the FSM sitting in IDLE grants it immediately
    nxt(); ifu_req = 1'b1; ifu_addr = 5'd7; settle();
    chk("v_ifu_gnt", 8'(d0_ifu_gnt), 8'd1);
    nxt(); ifu_req = 1'b0; settle();
    chk("v_mem_re", 8'(d0_re), 8'd1);
    nxt(); settle();
    chk("v_ifu_done", 8'(d0_ifu_done), 8'd1);
    chk("v_rdata", d0_rdata, 8'h11);

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 32x8 unified instruction/stack memory between two requesters.
- Instruction-fetch port (ifu): read-only.
- Stack-datapath port (stk): read and write.

Each granted request becomes one registered memory access. The block handles the memory's one-cycle registered read latency and returns a completion pulse with read data to the owning requester. It sits between the multi-cycle controller/datapath and the memory block.

Parameters:
ADDR_W, 5, memory address width (32 words)
DATA_W, 8, memory word width
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = stk always wins over ifu

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
ifu_req  in  1  fetch read request; held until ifu_gnt
ifu_addr  in  ADDR_W  fetch address; held with ifu_req
ifu_gnt  out  1  one-cycle pulse: fetch request accepted
ifu_done  out  1  one-cycle pulse: rdata valid for fetch
stk_req  in  1  stack request; held until stk_gnt
stk_we  in  1  1 = write, 0 = read; held with stk_req
stk_addr  in  ADDR_W  stack address
stk_wdata  in  DATA_W  stack write data
stk_gnt  out  1  one-cycle pulse: stack request accepted
stk_done  out  1  one-cycle pulse: stack access complete (rdata valid if read)
rdata  out  DATA_W  read data, shared by both ports, qualified by *_done
mem_we  out  1  to memory write enable
mem_re  out  1  to memory read enable
mem_addr  out  ADDR_W  to memory address
mem_wd  out  DATA_W  to memory write data
mem_rd  in  DATA_W  from memory registered output

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Grant window: grants are issued only in IDLE or RESP. gnt is combinational from state, requests and arbitration. At most one gnt per cycle.
- On gnt, the arbiter registers:
  - owner
  - op: ifu is always a read
  - addr
  - wdata
- Transitions:
  - IDLE/RESP with a grant -> ACCESS.
  - IDLE/RESP without a grant -> IDLE.
  - ACCESS -> RESP unconditionally.
- ACCESS:
  - mem_re = ~op_we; mem_we = op_we.
  - mem_addr/mem_wd come from the registered values.
  - The memory performs the access on the ACCESS->RESP edge.
- RESP:
  - owner's done = 1 for exactly one cycle.
  - rdata = mem_rd, valid for reads.
  - For writes, done still pulses and rdata is don't-care.
- Latency:
  - Request granted in cycle N -> memory strobe in N+1 -> done in N+2.
  - Back-to-back throughput is one access per 2 cycles, because RESP may grant the next request.
- mem_we/mem_re are 0 in every state except ACCESS. mem_addr/mem_wd hold their last values outside ACCESS.
- Arbitration:
  - FIXED_PRIO=0: on simultaneous ifu_req and stk_req, grant the port not served last. last_owner resets to ifu, so stk wins the first tie.
  - FIXED_PRIO=1: stk wins every tie.
  - A lone request is always granted in an open grant window.
- Requesters must keep req/addr/data stable until gnt. After gnt, req may stay high to request again; it is re-arbitrated in the RESP window.
- Write then read of the same address: serialised, so the read returns the newly written value.
- Reset (rst=0 at a rising edge):
  - state = IDLE, last_owner = ifu.
  - All gnt/done/mem_we/mem_re = 0.
  - mem_addr = 0, mem_wd = 0, rdata = 0.
  - An in-flight transaction is dropped: no done is issued, and a write in ACCESS is not performed if reset is asserted in that cycle.
  - Memory contents are untouched.
- No grants while rst = 0.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - owner encoding (OWN_IFU=1'b0, OWN_STK=1'b1)
  - ADDR_W/DATA_W defaults
- One sub-module, rr_arb2: 2-input round-robin/fixed-priority picker with a last_owner register, update enable and FIXED_PRIO parameter.
- The FSM and the datapath registers stay in the top module.

Test Plan:
- Memory preloaded with word[3]=8'hA5; ifu_req=1, ifu_addr=3 at cycle 0 -> ifu_gnt at cycle 0, mem_re=1/mem_addr=3 at cycle 1, ifu_done=1 and rdata=8'hA5 at cycle 2, stk_done stays 0.
- stk write addr=10, wdata=8'h3C, then stk read addr=10 -> mem_we pulses once with mem_addr=10; the read's stk_done shows rdata=8'h3C; the second gnt occurs in the first write's RESP cycle.
- ifu_req and stk_req both held high for 8 cycles, FIXED_PRIO=0 -> grant order stk, ifu, stk, ifu; done pulses every 2 cycles to the matching owner.
- Same stimulus with FIXED_PRIO=1 -> stk granted every window, ifu never granted while stk_req is high.
- rst driven low during ACCESS of stk write addr=7, wdata=8'hFF -> no stk_done; memory word 7 unchanged; all outputs 0 the next cycle; state IDLE.
- No requests for 5 cycles -> mem_we=mem_re=0 and no gnt/done throughout.
